fd_request_sequencer: RTL and testbench



---
 rtl/fd_request_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fd_request_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_request_sequencer.sv
// Request FIFO and issue/capture sequencer wrapped around the combinational fast_divider.
// Results are returned in request order, each carrying the 8-bit tag assigned at acceptance.
module fd_request_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic [WIDTH-1:0]         req_dividend_in,
    input  logic [WIDTH-1:0]         req_divisor_in,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_dbz_in,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [WIDTH-1:0]         rsp_quotient_out,
    output logic [WIDTH-1:0]         rsp_remainder_out,
    output logic                     rsp_dbz_out,
    output logic [7:0]               rsp_tag_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     busy_out
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int ENTRY_W = 2 * WIDTH + 8;
    localparam logic [PTR_W:0]   FULL   = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         tag_next;
    logic [7:0]         cur_tag;
    logic [CNT_W-1:0]   settle_cnt;
    logic               push;
    logic               pop;
    logic               capture;
    logic               release_rsp;
    logic               fifo_nonempty;
    logic [ENTRY_W-1:0] head;

    assign req_ready_out = (count_out != FULL);
    assign fifo_nonempty = (count_out != '0);
    assign push          = req_valid_in && req_ready_out;
    assign busy_out      = (state != S_IDLE) || fifo_nonempty;
    assign head          = fifo_mem[rd_ptr];

    // Storage carries no reset: pointers and count alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_dividend_in, req_divisor_in, tag_next};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_out <= '0;
            tag_next  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                tag_next <= tag_next + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_out <= count_out + 1'b1;
                2'b01:   count_out <= count_out - 1'b1;
                default: count_out <= count_out;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (settle_cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_in) begin
                    release_rsp = 1'b1;
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Issue side: divider operands only move on a pop, so they stay put through RESP/IDLE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            cur_tag          <= '0;
            settle_cnt       <= '0;
        end else if (pop) begin
            div_dividend_out <= head[ENTRY_W-1 -: WIDTH];
            div_divisor_out  <= head[8 +: WIDTH];
            cur_tag          <= head[7:0];
            settle_cnt       <= SETTLE;
        end else if (state == S_WAIT) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_valid_out     <= 1'b0;
            rsp_quotient_out  <= '0;
            rsp_remainder_out <= '0;
            rsp_dbz_out       <= 1'b0;
            rsp_tag_out       <= '0;
        end else if (capture) begin
            rsp_valid_out     <= 1'b1;
            rsp_quotient_out  <= div_quotient_in;
            rsp_remainder_out <= div_remainder_in;
            rsp_dbz_out       <= div_dbz_in;
            rsp_tag_out       <= cur_tag;
        end else if (release_rsp) begin
            rsp_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fd_request_sequencer.sv
// Bench for fd_request_sequencer: an ideal divider stand-in, an in-order response
// model fed from observed request handshakes, and directed scenarios with literal expectations.
module tb_fd_request_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend = '0;
    logic [WIDTH-1:0] req_divisor = '0;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_dbz;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic             rsp_dbz;
    logic [7:0]       rsp_tag;
    logic [2:0]       count;
    logic             busy;

    int n_checks = 0;
    int n_fail = 0;

    fd_request_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(1)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .req_valid_in      (req_valid),
        .req_ready_out     (req_ready),
        .req_dividend_in   (req_dividend),
        .req_divisor_in    (req_divisor),
        .div_dividend_out  (div_dividend),
        .div_divisor_out   (div_divisor),
        .div_quotient_in   (div_quotient),
        .div_remainder_in  (div_remainder),
        .div_dbz_in        (div_dbz),
        .rsp_valid_out     (rsp_valid),
        .rsp_ready_in      (rsp_ready),
        .rsp_quotient_out  (rsp_quotient),
        .rsp_remainder_out (rsp_remainder),
        .rsp_dbz_out       (rsp_dbz),
        .rsp_tag_out       (rsp_tag),
        .count_out         (count),
        .busy_out          (busy)
    );

    always #5 clk = ~clk;

    // Divider stand-in: divide by zero yields all-ones quotient and the dividend as remainder.
    function automatic logic [2*WIDTH:0] div_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (b == '0) return {{WIDTH{1'b1}}, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    always_comb begin
        {div_quotient, div_remainder, div_dbz} = div_ref(div_dividend, div_divisor);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic [7:0] tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_tag = 8'd0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_q, prev_r, prev_tag;
    logic       prev_dbz;

    // Reference: every accepted request produces exactly one response, in order, with the next tag.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_tag  = 8'd0;
            prev_stall = 1'b0;
        end else begin
            check("ready_vs_count", req_ready, (count != 3'(DEPTH)));
            if (prev_stall) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_fields", {rsp_quotient, rsp_remainder, rsp_dbz, rsp_tag},
                      {prev_q, prev_r, prev_dbz, prev_tag});
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_quotient", rsp_quotient, e.q);
                    check("rsp_remainder", rsp_remainder, e.r);
                    check("rsp_dbz", rsp_dbz, e.dbz);
                    check("rsp_tag", rsp_tag, e.tag);
                end
            end
            if (req_valid && req_ready) begin
                exp_t e;
                {e.q, e.r, e.dbz} = div_ref(req_dividend, req_divisor);
                e.tag = model_tag;
                exp_q.push_back(e);
                model_tag = model_tag + 8'd1;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_q     = rsp_quotient;
            prev_r     = rsp_remainder;
            prev_dbz   = rsp_dbz;
            prev_tag   = rsp_tag;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int k;
        k = 0;
        req_dividend = a;
        req_divisor  = b;
        req_valid    = 1'b1;
        while (!req_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("send_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] dvd4 [6] = '{50, 61, 72, 83, 94, 105};
    logic [7:0] dvs4 [6] = '{2, 3, 4, 5, 6, 7};
    logic [7:0] q4   [5] = '{25, 20, 18, 16, 15};

    initial begin
        int acc;
        logic [7:0] a;

        // 1: reset state
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_quotient, rsp_remainder, rsp_dbz, rsp_tag}, 0);
        check("rst_div", {div_dividend, div_divisor}, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2: single request latency
        req_dividend = 8'd100;
        req_divisor  = 8'd7;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t2_count_e0", count, 1);
        @(posedge clk);
        #1;
        check("t2_div_dividend", div_dividend, 100);
        check("t2_div_divisor", div_divisor, 7);
        check("t2_valid_e1", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("t2_valid_e2", rsp_valid, 1);
        check("t2_quotient", rsp_quotient, 14);
        check("t2_remainder", rsp_remainder, 2);
        check("t2_dbz", rsp_dbz, 0);
        check("t2_tag", rsp_tag, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_busy_after", busy, 0);
        check("t2_valid_after", rsp_valid, 0);

        // 3: divide by zero then a normal request
        do_reset();
        rsp_ready = 1'b1;
        send(8'd55, 8'd0);
        wait_rsp();
        check("t3_dbz", rsp_dbz, 1);
        check("t3_dbz_tag", rsp_tag, 0);
        @(posedge clk);
        #1;
        send(8'd9, 8'd3);
        wait_rsp();
        check("t3_quotient", rsp_quotient, 3);
        check("t3_remainder", rsp_remainder, 0);
        check("t3_nodbz", rsp_dbz, 0);
        check("t3_tag", rsp_tag, 1);
        @(posedge clk);
        #1;

        // 4: fill under backpressure
        do_reset();
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_dividend = dvd4[i];
            req_divisor  = dvs4[i];
            req_valid    = 1'b1;
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("t4_accepted", acc, 5);
        check("t4_full_ready", req_ready, 0);
        check("t4_full_count", count, 4);
        repeat (20) @(posedge clk);
        #1;
        check("t4_hold_valid", rsp_valid, 1);
        check("t4_hold_tag", rsp_tag, 0);
        check("t4_hold_quotient", rsp_quotient, q4[0]);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_ready_after_pop", req_ready, 1);
        for (int i = 1; i < 5; i++) begin
            wait_rsp();
            check("t4_drain_tag", rsp_tag, i);
            check("t4_drain_quotient", rsp_quotient, q4[i]);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("t4_idle", busy, 0);

        // 5: push coinciding with a RESP pop at count 2
        do_reset();
        rsp_ready = 1'b0;
        send(8'd40, 8'd5);
        send(8'd41, 8'd6);
        send(8'd99, 8'd10);
        check("t5_count_before", count, 2);
        check("t5_valid_before", rsp_valid, 1);
        check("t5_first_quotient", rsp_quotient, 8);
        req_dividend = 8'd200;
        req_divisor  = 8'd9;
        req_valid    = 1'b1;
        rsp_ready    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t5_count_same", count, 2);
        check("t5_valid_cleared", rsp_valid, 0);
        wait_rsp();
        check("t5_tag1", rsp_tag, 1);
        check("t5_q1", {rsp_quotient, rsp_remainder}, {8'd6, 8'd5});
        @(posedge clk);
        #1;
        wait_rsp();
        check("t5_tag2", rsp_tag, 2);
        check("t5_q2", {rsp_quotient, rsp_remainder}, {8'd9, 8'd9});
        @(posedge clk);
        #1;
        wait_rsp();
        check("t5_tag3", rsp_tag, 3);
        check("t5_q3", {rsp_quotient, rsp_remainder}, {8'd22, 8'd2});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_model_empty", exp_q.size(), 0);
        check("t5_idle", busy, 0);

        // 6: reset while in WAIT with three queued
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(10 + i), 8'd3);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("t6_count_wait", count, 3);
        check("t6_valid_wait", rsp_valid, 0);
        check("t6_busy_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", rsp_valid, 0);
        check("t6_rst_div", {div_dividend, div_divisor}, 0);
        check("t6_rst_ready", req_ready, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(8'd20, 8'd6);
        wait_rsp();
        check("t6_quotient", rsp_quotient, 3);
        check("t6_remainder", rsp_remainder, 2);
        check("t6_tag", rsp_tag, 0);
        @(posedge clk);
        #1;

        // Tag wrap over 257 requests
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            a = i[7:0];
            send(a, 8'((i % 7) + 1));
            wait_rsp();
            check("wrap_tag", rsp_tag, a);
            if (i >= 255) check("wrap_edge_tag", rsp_tag, (i == 255) ? 255 : 0);
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("end_model_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
